// File: rtl/detect_frame_ctrl_pkg.sv
// Shared types and constants for the detector frame controller.
// Holds the FSM state encoding, the default frame geometry and the result width.
package detect_frame_ctrl_pkg;

    localparam int IMG_H_DEF  = 164;
    localparam int SETTLE_DEF = 2;
    localparam int RES_W      = 32;
    localparam int LOST_W     = 4;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_WAIT_VS  = 3'd1,
        ST_ACTIVE   = 3'd2,
        ST_SETTLE_W = 3'd3,
        ST_CAPTURE  = 3'd4
    } state_t;

    // Saturating increment for the empty-frame run counter.
    function automatic logic [LOST_W-1:0] sat_inc(input logic [LOST_W-1:0] v);
        return (v == {LOST_W{1'b1}}) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/detect_frame_ctrl_frame_sync_edge.sv
// Registers vsync and data-enable once and derives the frame-start
// (vsync rising) and line-end (de falling) event pulses.
module frame_sync_edge (
    input  logic clk,
    input  logic rst_n,
    input  logic i_vsync,
    input  logic i_de,
    output logic frame_start,
    output logic line_end
);

    logic vsync_q;
    logic de_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vsync_q <= 1'b0;
            de_q    <= 1'b0;
        end else begin
            vsync_q <= i_vsync;
            de_q    <= i_de;
        end
    end

    assign frame_start = i_vsync & ~vsync_q;
    assign line_end    = de_q & ~i_de;

endmodule

// File: rtl/detect_frame_ctrl.sv
// Frame-synchronous capture of detector results with a valid/ready result
// port, lost-track tracking and sticky overrun / frame-length error flags.
module detect_frame_ctrl
    import detect_frame_ctrl_pkg::*;
#(
    parameter int IMG_H  = IMG_H_DEF,
    parameter int SETTLE = SETTLE_DEF,
    parameter int FCNT_W = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    i_vsync,
    input  logic                    i_de,
    input  logic signed [RES_W-1:0] i_mid_x,
    input  logic signed [RES_W-1:0] i_mid_y,
    input  logic signed [RES_W-1:0] i_p_sum,
    input  logic                    i_cfg_en,
    input  logic [RES_W-1:0]        i_cfg_min_area,
    input  logic [LOST_W-1:0]       i_cfg_lost_n,
    input  logic                    i_clr,
    input  logic                    i_res_ready,
    output logic                    o_res_valid,
    output logic signed [RES_W-1:0] o_res_x,
    output logic signed [RES_W-1:0] o_res_y,
    output logic signed [RES_W-1:0] o_res_area,
    output logic                    o_res_found,
    output logic [FCNT_W-1:0]       o_frame_cnt,
    output logic                    o_lost,
    output logic                    o_overrun,
    output logic                    o_frm_err,
    output logic                    o_busy
);

    // Handshake: a result is transferred on every cycle where o_res_valid
    // and i_res_ready are both high; o_res_valid then drops the next cycle
    // unless a new capture lands on that same edge.

    localparam int LCNT_W      = $clog2(IMG_H + 1);
    localparam int SCNT_W      = (SETTLE < 1) ? 1 : $clog2(SETTLE + 1);
    localparam int SETTLE_LAST = (SETTLE > 0) ? SETTLE - 1 : 0;

    state_t              state;
    state_t              state_next;
    logic                frame_start;
    logic                line_end;
    logic [LCNT_W-1:0]   line_cnt;
    logic [SCNT_W-1:0]   settle_cnt;
    logic                cfg_en;
    logic [RES_W-1:0]    cfg_min_area;
    logic [LOST_W-1:0]   cfg_lost_n;
    logic [LOST_W-1:0]   lost_cnt;
    logic                last_line;
    logic                capture;
    logic                cap_found;
    logic                frm_err_set;

    frame_sync_edge u_edge (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_vsync     (i_vsync),
        .i_de        (i_de),
        .frame_start (frame_start),
        .line_end    (line_end)
    );

    assign last_line   = line_end && (line_cnt == LCNT_W'(IMG_H - 1));
    assign capture     = (state == ST_CAPTURE);
    // Negative areas never count as found, even though the compare is unsigned.
    assign cap_found   = ~i_p_sum[RES_W-1] && ($unsigned(i_p_sum) >= cfg_min_area);
    assign frm_err_set = (state == ST_ACTIVE) && frame_start && i_cfg_en;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE:     if (i_cfg_en) state_next = ST_WAIT_VS;
            ST_WAIT_VS:  if (frame_start) state_next = ST_ACTIVE;
            ST_ACTIVE:   if (!frame_start && last_line) state_next = ST_SETTLE_W;
            ST_SETTLE_W: if (settle_cnt == SCNT_W'(SETTLE_LAST)) state_next = ST_CAPTURE;
            ST_CAPTURE:  state_next = ST_WAIT_VS;
            default:     state_next = ST_IDLE;
        endcase
        // The enable shadow reloads on every frame start; a disabled frame
        // drops whatever was in flight.
        if (frame_start && !i_cfg_en) state_next = ST_IDLE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            line_cnt     <= '0;
            settle_cnt   <= '0;
            cfg_en       <= 1'b0;
            cfg_min_area <= '0;
            cfg_lost_n   <= '0;
        end else begin
            if (frame_start) begin
                line_cnt     <= '0;
                cfg_en       <= i_cfg_en;
                cfg_min_area <= i_cfg_min_area;
                cfg_lost_n   <= i_cfg_lost_n;
            end else if (state == ST_ACTIVE && line_end) begin
                line_cnt <= line_cnt + 1'b1;
            end
            if (state == ST_SETTLE_W) settle_cnt <= settle_cnt + 1'b1;
            else                      settle_cnt <= '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            o_res_valid <= 1'b0;
            o_res_x     <= '0;
            o_res_y     <= '0;
            o_res_area  <= '0;
            o_res_found <= 1'b0;
            o_frame_cnt <= '0;
            lost_cnt    <= '0;
            o_overrun   <= 1'b0;
            o_frm_err   <= 1'b0;
        end else begin
            if (capture) begin
                o_res_x     <= i_mid_x;
                o_res_y     <= i_mid_y;
                o_res_area  <= i_p_sum;
                o_res_found <= cap_found;
                o_frame_cnt <= o_frame_cnt + 1'b1;
                lost_cnt    <= cap_found ? '0 : sat_inc(lost_cnt);
                o_res_valid <= 1'b1;
            end else if (i_res_ready) begin
                o_res_valid <= 1'b0;
            end

            if (capture && o_res_valid && !i_res_ready) o_overrun <= 1'b1;
            else if (i_clr)                             o_overrun <= 1'b0;

            if (frm_err_set) o_frm_err <= 1'b1;
            else if (i_clr)  o_frm_err <= 1'b0;
        end
    end

    assign o_lost = (cfg_lost_n != '0) && (lost_cnt >= cfg_lost_n);
    assign o_busy = (state != ST_IDLE);

endmodule
